// File: rtl/ysyx_23060187_pkg.sv
// ysyx_23060187_pkg: shared register-file widths and sizes
package ysyx_23060187_pkg;
  localparam int DEF_ADDR_WIDTH = 5;
  localparam int DEF_DATA_WIDTH = 32;
  localparam int NREGS = 2 ** DEF_ADDR_WIDTH;
endpackage

// File: rtl/ysyx_23060187_regfile_sb_if.sv
// ysyx_23060187_regfile_sb_if: decode/issue/writeback bundle for the scoreboarded regfile
interface ysyx_23060187_regfile_sb_if
  import ysyx_23060187_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int NR_READ = 2
);
  logic wen;
  logic [ADDR_WIDTH-1:0] waddr;
  logic [DATA_WIDTH-1:0] wdata;
  logic [NR_READ*ADDR_WIDTH-1:0] raddr;
  logic [NR_READ*DATA_WIDTH-1:0] rdata;
  logic [NR_READ-1:0] rbusy;
  logic iss_valid;
  logic [ADDR_WIDTH-1:0] iss_rd;
  logic flush;
  logic [DATA_WIDTH-1:0] dbg_data;
  logic [ADDR_WIDTH:0] busy_cnt;
  modport master (output wen, waddr, wdata, raddr, iss_valid, iss_rd, flush,
                  input rdata, rbusy, dbg_data, busy_cnt);
  modport slave (input wen, waddr, wdata, raddr, iss_valid, iss_rd, flush,
                 output rdata, rbusy, dbg_data, busy_cnt);
endinterface

// File: rtl/ysyx_23060187_sb_vec.sv
// ysyx_23060187_sb_vec: per-register busy bits with a popcount kept as a running counter
module ysyx_23060187_sb_vec
  import ysyx_23060187_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    flush,
  input  logic                    clr,
  input  logic [ADDR_WIDTH-1:0]   clr_idx,
  input  logic                    set,
  input  logic [ADDR_WIDTH-1:0]   set_idx,
  output logic [2**ADDR_WIDTH-1:0] busy,
  output logic [ADDR_WIDTH:0]     busy_cnt
);
  logic clr_en, set_en, inc, dec;
  logic [2**ADDR_WIDTH-1:0] busy_nxt;
  assign clr_en = clr && clr_idx != '0;
  assign set_en = set && set_idx != '0;
  assign inc = set_en && !busy[set_idx];
  // a clear that is re-set in the same cycle leaves the register outstanding
  assign dec = clr_en && busy[clr_idx] && !(set_en && set_idx == clr_idx);
  always_comb begin
    busy_nxt = busy;
    if (clr_en) busy_nxt[clr_idx] = 1'b0;
    if (set_en) busy_nxt[set_idx] = 1'b1;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy <= '0;
      busy_cnt <= '0;
    end else if (flush) begin
      busy <= '0;
      busy_cnt <= '0;
    end else begin
      busy <= busy_nxt;
      busy_cnt <= busy_cnt + (ADDR_WIDTH+1)'(inc) - (ADDR_WIDTH+1)'(dec);
    end
  end
endmodule

// File: rtl/ysyx_23060187_regfile_sb.sv
// ysyx_23060187_regfile_sb: GPR file with N combinational read ports, optional write bypass
// and a busy scoreboard between issue and writeback
module ysyx_23060187_regfile_sb
  import ysyx_23060187_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int NR_READ = 2,
  parameter int BYPASS = 1,
  parameter int DBG_REG = 10
) (
  input logic clk,
  input logic rst_n,
  ysyx_23060187_regfile_sb_if.slave bus
);
  localparam int NR = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] DBG_IDX = ADDR_WIDTH'(DBG_REG);
  logic [DATA_WIDTH-1:0] rf [NR];
  logic [NR-1:0] busy;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NR; i++) rf[i] <= '0;
    end else if (bus.wen && bus.waddr != '0) begin
      rf[bus.waddr] <= bus.wdata;
    end
  end
  ysyx_23060187_sb_vec #(.ADDR_WIDTH(ADDR_WIDTH)) u_sb (
    .clk      (clk),
    .rst_n    (rst_n),
    .flush    (bus.flush),
    .clr      (bus.wen),
    .clr_idx  (bus.waddr),
    .set      (bus.iss_valid),
    .set_idx  (bus.iss_rd),
    .busy     (busy),
    .busy_cnt (bus.busy_cnt)
  );
  for (genvar g = 0; g < NR_READ; g++) begin : g_rd
    logic [ADDR_WIDTH-1:0] ra;
    logic hit;
    assign ra = bus.raddr[g*ADDR_WIDTH +: ADDR_WIDTH];
    // forwarding also hides the busy bit the same writeback is about to clear
    assign hit = BYPASS != 0 && bus.wen && bus.waddr == ra;
    assign bus.rdata[g*DATA_WIDTH +: DATA_WIDTH] = ra == '0 ? '0 : hit ? bus.wdata : rf[ra];
    assign bus.rbusy[g] = ra != '0 && !hit && busy[ra];
  end
  assign bus.dbg_data = rf[DBG_IDX];
endmodule

// File: tb/tb_ysyx_23060187_regfile_sb.sv
// tb_ysyx_23060187_regfile_sb: directed vectors, scoreboard queue drained by a negedge monitor;
// a BYPASS=0 copy shares the stimulus
module tb_ysyx_23060187_regfile_sb;
  typedef struct {
    int kind;
    int port;
    logic [31:0] val;
    string name;
  } exp_t;
  logic clk = 0;
  logic rst_n = 0;
  int vectors = 0;
  int miscompares = 0;
  exp_t q[$];
  ysyx_23060187_regfile_sb_if #(.ADDR_WIDTH(5), .DATA_WIDTH(32), .NR_READ(2)) b1 ();
  ysyx_23060187_regfile_sb_if #(.ADDR_WIDTH(5), .DATA_WIDTH(32), .NR_READ(2)) b0 ();
  ysyx_23060187_regfile_sb #(.BYPASS(1)) u_byp (.clk(clk), .rst_n(rst_n), .bus(b1));
  ysyx_23060187_regfile_sb #(.BYPASS(0)) u_nob (.clk(clk), .rst_n(rst_n), .bus(b0));
  assign b0.wen = b1.wen;
  assign b0.waddr = b1.waddr;
  assign b0.wdata = b1.wdata;
  assign b0.raddr = b1.raddr;
  assign b0.iss_valid = b1.iss_valid;
  assign b0.iss_rd = b1.iss_rd;
  assign b0.flush = b1.flush;
  always #5 clk = ~clk;

  function automatic logic [31:0] actual(exp_t e);
    case (e.kind)
      0: actual = b1.rdata[e.port*32 +: 32];
      1: actual = {31'd0, b1.rbusy[e.port]};
      2: actual = {26'd0, b1.busy_cnt};
      3: actual = b1.dbg_data;
      4: actual = b0.rdata[e.port*32 +: 32];
      5: actual = {31'd0, b0.rbusy[e.port]};
      6: actual = {26'd0, b0.busy_cnt};
      default: actual = 'x;
    endcase
  endfunction

  initial forever begin
    @(negedge clk);
    while (q.size() > 0) begin
      exp_t e;
      logic [31:0] a;
      e = q.pop_front();
      a = actual(e);
      vectors++;
      if (a !== e.val) begin
        miscompares++;
        $display("FAIL %s: got %h expected %h at %0t", e.name, a, e.val, $time);
      end
    end
  end

  task automatic expect_v(input int kind, input int port, input logic [31:0] val, input string name);
    exp_t e;
    e.kind = kind;
    e.port = port;
    e.val = val;
    e.name = name;
    q.push_back(e);
  endtask

  task automatic drive(input logic w, input logic [4:0] wa, input logic [31:0] wd,
                       input logic iv, input logic [4:0] rd, input logic fl,
                       input logic [4:0] r0, input logic [4:0] r1);
    @(posedge clk);
    #1;
    b1.wen = w;
    b1.waddr = wa;
    b1.wdata = wd;
    b1.iss_valid = iv;
    b1.iss_rd = rd;
    b1.flush = fl;
    b1.raddr = {r1, r0};
  endtask

  task automatic idle(input logic [4:0] r0, input logic [4:0] r1);
    drive(0, 0, 0, 0, 0, 0, r0, r1);
  endtask

  initial begin
    b1.wen = 1;
    b1.waddr = 5;
    b1.wdata = 32'hDEAD;
    b1.iss_valid = 0;
    b1.iss_rd = 0;
    b1.flush = 0;
    b1.raddr = {5'd0, 5'd5};
    repeat (3) @(posedge clk);
    #1;
    b1.wen = 0;
    rst_n = 1;
    idle(5, 0);
    expect_v(0, 0, 0, "reset_rdata_x5");
    expect_v(1, 0, 0, "reset_rbusy");
    expect_v(2, 0, 0, "reset_busy_cnt");
    expect_v(3, 0, 0, "reset_dbg");
    drive(1, 0, 32'hFFFFFFFF, 1, 0, 0, 0, 0);
    expect_v(0, 0, 0, "x0_rdata_bypass");
    expect_v(1, 0, 0, "x0_rbusy");
    idle(0, 0);
    expect_v(0, 0, 0, "x0_rdata_after");
    expect_v(1, 0, 0, "x0_rbusy_after");
    expect_v(2, 0, 0, "x0_busy_cnt");
    drive(1, 3, 32'h1234, 0, 0, 0, 3, 3);
    expect_v(0, 0, 32'h1234, "bypass_rdata0");
    expect_v(0, 1, 32'h1234, "bypass_rdata1");
    expect_v(4, 0, 0, "nobypass_old");
    idle(3, 3);
    expect_v(4, 0, 32'h1234, "nobypass_new");
    expect_v(0, 1, 32'h1234, "stored_x3");
    drive(0, 0, 0, 1, 7, 0, 7, 0);
    expect_v(1, 0, 0, "issue_not_yet_busy");
    expect_v(2, 0, 0, "issue_cnt_before");
    idle(7, 0);
    expect_v(1, 0, 1, "x7_busy");
    expect_v(5, 0, 1, "x7_busy_nob");
    expect_v(2, 0, 1, "cnt_one");
    drive(1, 7, 32'h55, 0, 0, 0, 7, 0);
    expect_v(1, 0, 0, "wb_rbusy_bypass");
    expect_v(0, 0, 32'h55, "wb_rdata_bypass");
    expect_v(5, 0, 1, "wb_rbusy_nob");
    expect_v(2, 0, 1, "wb_cnt_before_edge");
    idle(7, 0);
    expect_v(2, 0, 0, "wb_cnt_after");
    expect_v(1, 0, 0, "wb_rbusy_after");
    expect_v(5, 0, 0, "wb_rbusy_nob_after");
    expect_v(6, 0, 0, "wb_cnt_nob");
    drive(0, 0, 0, 1, 7, 0, 7, 0);
    idle(7, 0);
    expect_v(2, 0, 1, "reissue_cnt");
    drive(1, 7, 32'h77, 1, 7, 0, 7, 0);
    expect_v(1, 0, 0, "simul_rbusy_hit");
    expect_v(0, 0, 32'h77, "simul_rdata_hit");
    idle(7, 0);
    expect_v(1, 0, 1, "simul_still_busy");
    expect_v(2, 0, 1, "simul_cnt");
    expect_v(4, 0, 32'h77, "simul_data");
    drive(1, 9, 32'h99, 0, 0, 0, 9, 7);
    idle(9, 7);
    expect_v(0, 0, 32'h99, "nonbusy_wb_data");
    expect_v(1, 1, 1, "nonbusy_wb_x7");
    expect_v(2, 0, 1, "nonbusy_wb_cnt");
    drive(1, 7, 0, 1, 1, 0, 1, 7);
    drive(0, 0, 0, 1, 2, 0, 1, 2);
    expect_v(2, 0, 1, "swap_cnt");
    drive(0, 0, 0, 1, 3, 0, 1, 3);
    expect_v(2, 0, 2, "cnt_two");
    drive(1, 12, 32'hC, 1, 4, 1, 1, 3);
    expect_v(2, 0, 3, "cnt_three");
    expect_v(1, 0, 1, "x1_busy");
    expect_v(1, 1, 1, "x3_busy");
    drive(1, 10, 32'd42, 0, 0, 0, 4, 1);
    expect_v(2, 0, 0, "flush_cnt");
    expect_v(1, 0, 0, "flush_drops_issue");
    expect_v(1, 1, 0, "flush_x1");
    expect_v(3, 0, 0, "dbg_not_bypassed");
    idle(12, 0);
    expect_v(3, 0, 32'd42, "dbg_after_write");
    expect_v(0, 0, 32'hC, "flush_write_kept");
    repeat (3) @(posedge clk);
    if (q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: got %0d pending expected 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
